// File: rtl/io_port_responder.sv
// I/O-space responder: output port, synchronized input port, edge capture
// with mask and interrupt, acked after a fixed number of wait states.
module io_port_responder #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'hF0,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  iom,
   input  logic                  wr_rdn,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ack,
   input  logic [DATA_WIDTH-1:0] pin_in,
   output logic [DATA_WIDTH-1:0] pin_out,
   output logic                  irq
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam int WS_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
   localparam state_t ACCEPT_NEXT = (WAIT_STATES == 0) ? S_RESP : S_WAIT;

   state_t                state;
   logic [3:0]            cnt;
   logic [3:0]            off;
   logic                  wr;
   logic [DATA_WIDTH-1:0] wd;
   logic [DATA_WIDTH-1:0] out_r;
   logic [DATA_WIDTH-1:0] sync1;
   logic [DATA_WIDTH-1:0] sync2;
   logic [DATA_WIDTH-1:0] prev;
   logic [DATA_WIDTH-1:0] edge_r;
   logic [DATA_WIDTH-1:0] mask_r;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic [DATA_WIDTH-1:0] rise;
   logic [DATA_WIDTH-1:0] clr;
   logic                  sel;

   assign sel = req && iom &&
      (addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
   assign rise    = sync2 & ~prev;
   assign pin_out = out_r;
   assign irq     = |(edge_r & mask_r);

   always_comb begin
      rd_mux = '0;
      case (off)
         4'd0:    rd_mux = out_r;
         4'd1:    rd_mux = sync2;
         4'd2:    rd_mux = edge_r;
         4'd3:    rd_mux = mask_r;
         default: rd_mux = '0;
      endcase
   end

   // W1C mask is only live on the completing edge of a write to EDGE
   always_comb begin
      clr = '0;
      if (state == S_RESP && wr && off == 4'd2) clr = wd;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         off    <= '0;
         wr     <= 1'b0;
         wd     <= '0;
         out_r  <= '0;
         sync1  <= '0;
         sync2  <= '0;
         prev   <= '0;
         edge_r <= '0;
         mask_r <= '0;
         rdata  <= '0;
         ack    <= 1'b0;
      end else begin
         sync1  <= pin_in;
         sync2  <= sync1;
         prev   <= sync2;
         // set wins over a simultaneous clear
         edge_r <= (edge_r & ~clr) | rise;
         ack    <= 1'b0;
         rdata  <= '0;
         unique case (state)
            S_IDLE: begin
               if (sel && !ack) begin
                  off   <= addr[3:0];
                  wr    <= wr_rdn;
                  wd    <= wdata;
                  cnt   <= 4'(WS_LOAD);
                  state <= ACCEPT_NEXT;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) state <= S_RESP;
               else cnt <= cnt - 4'd1;
            end
            S_RESP: begin
               ack   <= 1'b1;
               state <= S_IDLE;
               if (wr) begin
                  if (off == 4'd0) out_r  <= wd;
                  if (off == 4'd3) mask_r <= wd;
               end else begin
                  rdata <= rd_mux;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_io_port_responder.sv
// Scoreboard bench for io_port_responder: one instance with one wait
// state, one with none; a monitor checks every ack against a queue.
module tb_io_port_responder;

   typedef struct {
      int         cyc;
      logic [7:0] rd;
      bit         chk_rd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req = 1'b0;
   logic       req0 = 1'b0;
   logic       iom = 1'b0;
   logic       wr_rdn = 1'b0;
   logic [7:0] addr = '0;
   logic [7:0] wdata = '0;
   logic [7:0] pin_in = '0;
   logic [7:0] rdata, rdata0;
   logic [7:0] pin_out, pin_out0;
   logic       ack, ack0;
   logic       irq, irq0;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   exp_t q0[$];

   io_port_responder #(.WAIT_STATES(1)) dut (
      .clk(clk), .rst(rst), .req(req), .iom(iom), .wr_rdn(wr_rdn),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack),
      .pin_in(pin_in), .pin_out(pin_out), .irq(irq)
   );

   io_port_responder #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .iom(iom), .wr_rdn(wr_rdn),
      .addr(addr), .wdata(wdata), .rdata(rdata0), .ack(ack0),
      .pin_in(pin_in), .pin_out(pin_out0), .irq(irq0)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Monitor for the one-wait-state instance
   always @(negedge clk) begin
      exp_t e;
      if (ack) begin
         if (q.size() == 0) begin
            chk("unexpected_ack", 1, 0);
         end else begin
            e = q.pop_front();
            chk("ack_cycle", cyc, e.cyc);
            if (e.chk_rd) chk("rdata", int'(rdata), int'(e.rd));
         end
      end else begin
         chk("rdata_idle", int'(rdata), 0);
      end
   end

   // Monitor for the zero-wait-state instance
   always @(negedge clk) begin
      exp_t e;
      if (ack0) begin
         if (q0.size() == 0) begin
            chk("unexpected_ack0", 1, 0);
         end else begin
            e = q0.pop_front();
            chk("ack0_cycle", cyc, e.cyc);
            if (e.chk_rd) chk("rdata0", int'(rdata0), int'(e.rd));
         end
      end else begin
         chk("rdata0_idle", int'(rdata0), 0);
      end
   end

   task automatic acc(input bit d0, input bit w, input logic [7:0] a,
                      input logic [7:0] d, input bit io,
                      input bit exp_ack, input logic [7:0] erd);
      exp_t e;
      @(posedge clk);
      #1;
      iom    = io;
      wr_rdn = w;
      addr   = a;
      wdata  = d;
      if (d0) req0 = 1'b1;
      else req = 1'b1;
      if (exp_ack) begin
         e.cyc    = cyc + (d0 ? 0 : 1) + 2;
         e.rd     = erd;
         e.chk_rd = !w;
         if (d0) q0.push_back(e);
         else q.push_back(e);
      end
      @(posedge clk);
      #1;
      req  = 1'b0;
      req0 = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      exp_t e;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pin_out", int'(pin_out), 0);
      chk("rst_ack", int'(ack), 0);
      chk("rst_irq", int'(irq), 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst_pin_out", int'(pin_out), 0);
      chk("post_rst_rdata", int'(rdata), 0);
      chk("post_rst_irq", int'(irq), 0);

      acc(0, 1, 8'hF0, 8'hA5, 1, 1, 8'h00);
      chk("pin_out_a5", int'(pin_out), 'hA5);
      acc(0, 0, 8'hF0, 8'h00, 1, 1, 8'hA5);

      acc(0, 1, 8'hF3, 8'h04, 1, 1, 8'h00);
      acc(0, 0, 8'hF3, 8'h00, 1, 1, 8'h04);
      @(posedge clk);
      #1;
      pin_in = 8'h05;
      repeat (2) @(posedge clk);
      #1;
      chk("irq_before_edge", int'(irq), 0);
      @(posedge clk);
      #1;
      chk("irq_after_edge", int'(irq), 1);
      acc(0, 0, 8'hF2, 8'h00, 1, 1, 8'h05);
      acc(0, 0, 8'hF1, 8'h00, 1, 1, 8'h05);
      acc(0, 1, 8'hF2, 8'h04, 1, 1, 8'h00);
      chk("irq_cleared", int'(irq), 0);
      acc(0, 0, 8'hF2, 8'h00, 1, 1, 8'h01);

      acc(0, 1, 8'hE0, 8'h5A, 1, 0, 8'h00);
      acc(0, 1, 8'hF0, 8'h5A, 0, 0, 8'h00);
      chk("pin_out_unsel", int'(pin_out), 'hA5);

      acc(0, 1, 8'hF7, 8'hFF, 1, 1, 8'h00);
      acc(0, 0, 8'hF7, 8'h00, 1, 1, 8'h00);

      // Second request held through WAIT and RESP must be dropped
      @(posedge clk);
      #1;
      iom = 1'b1; wr_rdn = 1'b1; addr = 8'hF0; wdata = 8'h3C; req = 1'b1;
      e.cyc = cyc + 3; e.rd = 8'h00; e.chk_rd = 1'b0;
      q.push_back(e);
      @(posedge clk);
      #1;
      wdata = 8'h11;
      repeat (2) @(posedge clk);
      #1;
      req = 1'b0;
      repeat (4) @(posedge clk);
      chk("pin_out_first_wins", int'(pin_out), 'h3C);

      acc(1, 1, 8'hF0, 8'h77, 1, 1, 8'h00);
      chk("pin_out0_77", int'(pin_out0), 'h77);
      acc(1, 0, 8'hF0, 8'h00, 1, 1, 8'h77);

      // Reset while the access sits in WAIT
      @(posedge clk);
      #1;
      iom = 1'b1; wr_rdn = 1'b1; addr = 8'hF0; wdata = 8'hEE; req = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_ack", int'(ack), 0);
      chk("mid_rst_pin_out", int'(pin_out), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      chk("pin_out_after_abort", int'(pin_out), 0);
      acc(0, 1, 8'hF0, 8'h42, 1, 1, 8'h00);
      chk("pin_out_42", int'(pin_out), 'h42);

      repeat (3) @(posedge clk);
      chk("pending_acks", q.size(), 0);
      chk("pending_acks0", q0.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Bus-side responder for the CPU's I/O space; it answers accesses driven by the control unit's memory/I/O interface (iom, wr_rdn, MAR address, MDR data).
- Provides one 8-bit output port, one synchronized 8-bit input port, rising-edge capture with a mask, and an interrupt request back to the core.
- Every access completes with a single-cycle ack after a programmable number of wait states.

Parameters:
- DATA_WIDTH, 8, width of data bus and ports.
- ADDR_WIDTH, 8, width of address bus.
- BASE_ADDR, 8'hF0, base of the 16-location responder window; must be 16-aligned.
- WAIT_STATES, 1, extra cycles inserted before ack (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- req  in  1  access strobe from the initiator; sampled on rising clk.
- iom  in  1  1 = I/O space access; 0 = memory access, which is ignored.
- wr_rdn  in  1  1 = write, 0 = read.
- addr  in  ADDR_WIDTH  access address.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data; valid only while ack=1, otherwise 0.
- ack  out  1  single-cycle completion pulse.
- pin_in  in  DATA_WIDTH  asynchronous external inputs.
- pin_out  out  DATA_WIDTH  output port register.
- irq  out  1  interrupt request = |(EDGE & MASK).

Behaviour:
- Reset (rst=0, asynchronous):
  - pin_out, EDGE, MASK, both synchronizer stages and rdata = 0; ack = 0; FSM = IDLE; wait counter = 0.
- Address decode:
  - An access is selected when req=1, iom=1 and addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4].
  - Unselected requests are ignored: no ack, no state change.
- Register map (offset = addr[3:0]):
  - 0 OUT: R/W; drives pin_out.
  - 1 IN: RO; synchronized pin_in.
  - 2 EDGE: R / write-1-to-clear.
  - 3 MASK: R/W.
  - 4..15: read 0; writes ignored but still acked.
- FSM states IDLE, WAIT, RESP:
  - IDLE: a selected request latches addr[3:0], wr_rdn and wdata. Next state is WAIT, with the counter loaded to WAIT_STATES-1, or RESP directly when WAIT_STATES=0.
  - WAIT: decrement the counter; move to RESP when the counter is 0.
  - RESP: ack=1 for exactly one cycle, then return to IDLE. No back-to-back accept; a req seen during RESP is ignored.
- Latency: ack is high during the cycle that begins WAIT_STATES+1 rising edges after the edge that sampled req.
- Requests arriving while in WAIT or RESP are dropped. The initiator must hold off until ack.
- Read/write timing:
  - A register write takes effect on the edge that raises ack.
  - rdata is loaded on the same edge, from register values before that edge's updates, and cleared on the edge that drops ack.
- Input path:
  - pin_in passes through a 2-flop synchronizer (sync1 -> sync2). IN reads sync2.
  - A previous-value flop holds the last sync2 value. A rising edge (sync2 & ~prev) sets the matching EDGE bit.
  - Because the flops reset to 0, any pin high at reset release registers an edge 3 cycles later.
- EDGE conflict: if a W1C clear and a new edge hit the same bit in the same cycle, set wins.
- irq is combinational from the EDGE and MASK registers; it is glitch-free because both are registered.
- Reset mid-access: the FSM returns to IDLE, the pending access is discarded, and no ack is issued.

Test Plan:
- Reset with rst=0 and pin_in=8'h00, then release -> pin_out=0, ack=0, rdata=0, irq=0.
- Write offset 0 (addr=8'hF0, wr_rdn=1, wdata=8'hA5, req for 1 cycle), WAIT_STATES=1 -> ack high exactly 2 edges after the sample edge for 1 cycle; pin_out=8'hA5 from that edge. Then read 8'hF0 -> rdata=8'hA5 during ack only.
- pin_in 8'h00->8'h05 with MASK=8'h04 -> EDGE=8'h05 and irq=1 three edges later. Write 8'h04 to 8'hF2 -> EDGE=8'h01, irq=0.
- Access to addr=8'hE0, and an access with iom=0 at 8'hF0 -> no ack, pin_out unchanged.
- Second req issued during WAIT -> ignored; exactly one ack. With WAIT_STATES=0, ack follows on the next edge after the sample edge.
- rst asserted while in WAIT -> ack never rises, FSM in IDLE, and a new access after release completes normally.
